// File: rtl/home_alarm_pkg.sv
// Shared types and constants for the home-alarm annunciator: FSM states,
// alarm bit positions, alert codes and siren drive modes.
package home_alarm_pkg;

    typedef enum logic [1:0] {IDLE, ALERT, ACKED, ESCALATED} state_e;
    typedef enum logic [1:0] {SIREN_OFF, SIREN_CONT, SIREN_PULSE} siren_mode_e;

    localparam int FIRE_BIT = 2;
    localparam int BURG_BIT = 1;
    localparam int RAIN_BIT = 0;

    localparam logic [1:0] CODE_NONE = 2'd0;
    localparam logic [1:0] CODE_RAIN = 2'd1;
    localparam logic [1:0] CODE_BURG = 2'd2;
    localparam logic [1:0] CODE_FIRE = 2'd3;

    function automatic logic [1:0] alert_code_of(input logic [2:0] lat);
        if (lat[FIRE_BIT])      return CODE_FIRE;
        else if (lat[BURG_BIT]) return CODE_BURG;
        else if (lat[RAIN_BIT]) return CODE_RAIN;
        else                    return CODE_NONE;
    endfunction

    // Only the sounding states drive the siren; fire outranks the burglar beep.
    function automatic siren_mode_e siren_mode_of(input state_e st, input logic [2:0] lat);
        if (st != ALERT && st != ESCALATED) return SIREN_OFF;
        else if (lat[FIRE_BIT])             return SIREN_CONT;
        else if (lat[BURG_BIT])             return SIREN_PULSE;
        else                                return SIREN_OFF;
    endfunction

endpackage

// File: rtl/siren_pattern_gen.sv
// Siren waveform generator: off, continuous, or a square wave of period
// 2*BEEP_HALF that always begins with a high half when the pulse mode starts.
module siren_pattern_gen
    import home_alarm_pkg::*;
#(
    parameter int BEEP_HALF = 50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       restart,
    input  logic [1:0] mode,
    output logic       siren
);

    localparam int CW = (BEEP_HALF > 1) ? $clog2(BEEP_HALF) : 1;
    localparam logic [CW-1:0] LAST = CW'(BEEP_HALF - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          siren_q, siren_d;
    logic          pulsed_q;

    always_comb begin
        cnt_d   = '0;
        siren_d = 1'b0;
        case (siren_mode_e'(mode))
            SIREN_CONT: siren_d = 1'b1;
            SIREN_PULSE: begin
                if (restart || !pulsed_q) begin
                    siren_d = 1'b1;
                end else if (cnt_q == LAST) begin
                    siren_d = ~siren_q;
                end else begin
                    siren_d = siren_q;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            siren_q  <= 1'b0;
            pulsed_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            siren_q  <= siren_d;
            pulsed_q <= (mode == SIREN_PULSE);
        end
    end

    assign siren = siren_q;

endmodule

// File: rtl/alarm_annunciator.sv
// Alarm annunciator: latches {fire, burglar, rain} events, drives siren and
// strobe, handles acknowledge and escalates unacknowledged fire/burglar alarms.
module alarm_annunciator
    import home_alarm_pkg::*;
#(
    parameter int ESC_CYCLES = 1000,
    parameter int BEEP_HALF  = 50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] alarms,
    input  logic       armed,
    input  logic       ack,
    output logic       siren,
    output logic       strobe,
    output logic       dial_out,
    output logic [1:0] alert_code,
    output logic [2:0] latched
);

    localparam int EW = $clog2(ESC_CYCLES);
    localparam logic [EW-1:0] ESC_LAST = EW'(ESC_CYCLES - 1);

    state_e      state_q, state_d;
    logic [2:0]  latched_q, latched_d;
    logic [2:0]  prev_q;
    logic [EW-1:0] esc_q, esc_d, esc_inc;
    logic        dial_q, dial_d;
    logic        strobe_q, strobe_d;
    logic        restart;
    logic [1:0]  siren_mode;
    logic [2:0]  eff, rise;

    assign eff     = alarms & {1'b1, armed, 1'b1};
    assign rise    = eff & ~prev_q;
    assign esc_inc = (esc_q == ESC_LAST) ? esc_q : esc_q + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            latched_q <= '0;
            prev_q    <= '0;
            esc_q     <= '0;
            dial_q    <= 1'b0;
            strobe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            latched_q <= latched_d;
            prev_q    <= eff;
            esc_q     <= esc_d;
            dial_q    <= dial_d;
            strobe_q  <= strobe_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        latched_d = latched_q | eff;
        esc_d     = esc_q;
        restart   = 1'b0;
        case (state_q)
            IDLE: begin
                if (|eff) begin
                    state_d = ALERT;
                    esc_d   = '0;
                    restart = 1'b1;
                end
            end
            ALERT: begin
                esc_d = esc_inc;
                if (|rise) begin
                    esc_d = '0;
                end else if (ack) begin
                    state_d = ACKED;
                end else if (esc_inc == ESC_LAST &&
                             (latched_d[FIRE_BIT] || latched_d[BURG_BIT])) begin
                    state_d = ESCALATED;
                end
            end
            ACKED: begin
                // Bits no longer asserted drop out; (latched | eff) & eff == eff.
                latched_d = eff;
                if (|rise) begin
                    state_d = ALERT;
                    esc_d   = '0;
                    restart = 1'b1;
                end else if (latched_d == '0) begin
                    state_d = IDLE;
                end
            end
            ESCALATED: begin
                if (ack) state_d = ACKED;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dial_d     = (state_q == ALERT) && (state_d == ESCALATED);
        strobe_d   = (state_d != IDLE) && (|latched_d);
        siren_mode = siren_mode_of(state_d, latched_d);
    end

    siren_pattern_gen #(.BEEP_HALF(BEEP_HALF)) u_siren (
        .clk     (clk),
        .reset   (reset),
        .restart (restart),
        .mode    (siren_mode),
        .siren   (siren)
    );

    assign strobe     = strobe_q;
    assign dial_out   = dial_q;
    assign latched    = latched_q;
    assign alert_code = alert_code_of(latched_q);

endmodule

// File: tb/tb_alarm_annunciator.sv
// Directed bench for alarm_annunciator (ESC_CYCLES=8, BEEP_HALF=2) with a
// queue-based scoreboard checked by an independent monitor on the falling edge.
module tb_alarm_annunciator;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] alarms = 3'b000;
    logic       armed = 1'b1;
    logic       ack = 1'b0;
    logic       siren, strobe, dial_out;
    logic [1:0] alert_code;
    logic [2:0] latched;

    typedef struct packed {
        logic       siren;
        logic       strobe;
        logic       dial;
        logic [1:0] code;
        logic [2:0] lat;
    } obs_t;

    obs_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    alarm_annunciator #(.ESC_CYCLES(8), .BEEP_HALF(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .alarms     (alarms),
        .armed      (armed),
        .ack        (ack),
        .siren      (siren),
        .strobe     (strobe),
        .dial_out   (dial_out),
        .alert_code (alert_code),
        .latched    (latched)
    );

    always #5 clk = ~clk;

    function automatic obs_t o(input logic s, input logic st, input logic d,
                               input logic [1:0] c, input logic [2:0] l);
        obs_t r;
        r.siren = s; r.strobe = st; r.dial = d; r.code = c; r.lat = l;
        return r;
    endfunction

    // Apply inputs, clock one edge, then queue what the outputs must show.
    task automatic cyc(input logic [2:0] al, input logic arm, input logic ak,
                       input logic rst, input obs_t e, input string nm);
        alarms = al; armed = arm; ack = ak; reset = rst;
        @(posedge clk);
        #1;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            obs_t  e, a;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = o(siren, strobe, dial_out, alert_code, latched);
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s: got siren=%b strobe=%b dial=%b code=%0d latched=%b, expected siren=%b strobe=%b dial=%b code=%0d latched=%b",
                         nm, a.siren, a.strobe, a.dial, a.code, a.lat,
                         e.siren, e.strobe, e.dial, e.code, e.lat);
            end
        end
    end

    logic burg_pat [9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        cyc(3'b000, 1, 0, 1, o(0, 0, 0, 0, 3'b000), "reset0");
        cyc(3'b000, 1, 0, 1, o(0, 0, 0, 0, 3'b000), "reset1");

        // Fire only: escalates on the 8th edge, siren continuous throughout
        for (int k = 1; k <= 7; k++) cyc(3'b100, 1, 0, 0, o(1, 1, 0, 3, 3'b100), "fire_alert");
        cyc(3'b100, 1, 0, 0, o(1, 1, 1, 3, 3'b100), "fire_dial");
        for (int k = 0; k < 3; k++) cyc(3'b100, 1, 0, 0, o(1, 1, 0, 3, 3'b100), "fire_escalated");
        cyc(3'b100, 1, 1, 0, o(0, 1, 0, 3, 3'b100), "fire_ack");
        cyc(3'b100, 1, 1, 0, o(0, 1, 0, 3, 3'b100), "fire_acked_hold");
        cyc(3'b000, 1, 0, 0, o(0, 0, 0, 0, 3'b000), "fire_clear");

        // Burglar armed: beep 1,1,0,0,... and escalation at edge 8
        for (int k = 0; k < 9; k++)
            cyc(3'b010, 1, 0, 0, o(burg_pat[k], 1, (k == 7), 2, 3'b010), "burg_pattern");
        cyc(3'b010, 1, 1, 0, o(0, 1, 0, 2, 3'b010), "burg_ack");
        cyc(3'b000, 1, 0, 0, o(0, 0, 0, 0, 3'b000), "burg_clear");

        // Burglar disarmed: masked entirely
        for (int k = 0; k < 4; k++) cyc(3'b010, 0, 0, 0, o(0, 0, 0, 0, 3'b000), "burg_disarmed");
        cyc(3'b000, 0, 0, 0, o(0, 0, 0, 0, 3'b000), "disarmed_idle");

        // Disarm while burglar latched: bit survives until cleared in ACKED
        cyc(3'b010, 1, 0, 0, o(1, 1, 0, 2, 3'b010), "disarm_entry");
        cyc(3'b010, 0, 0, 0, o(1, 1, 0, 2, 3'b010), "disarm_sticky");
        cyc(3'b010, 0, 1, 0, o(0, 1, 0, 2, 3'b010), "disarm_ack");
        cyc(3'b010, 0, 0, 0, o(0, 0, 0, 0, 3'b000), "disarm_cleared");
        cyc(3'b000, 1, 0, 0, o(0, 0, 0, 0, 3'b000), "disarm_idle");

        // Rain only: never escalates, ack then drop returns to idle
        for (int k = 0; k < 20; k++) cyc(3'b001, 1, 0, 0, o(0, 1, 0, 1, 3'b001), "rain_alert");
        cyc(3'b001, 1, 1, 0, o(0, 1, 0, 1, 3'b001), "rain_ack");
        cyc(3'b000, 1, 0, 0, o(0, 0, 0, 0, 3'b000), "rain_clear");

        // Fire rise and ack together after a saturated rain timer
        for (int k = 0; k < 10; k++) cyc(3'b001, 1, 0, 0, o(0, 1, 0, 1, 3'b001), "rain_sat");
        cyc(3'b101, 1, 1, 0, o(1, 1, 0, 3, 3'b101), "rise_beats_ack");
        for (int k = 0; k < 6; k++) cyc(3'b101, 1, 0, 0, o(1, 1, 0, 3, 3'b101), "timer_restarted");
        cyc(3'b101, 1, 0, 0, o(1, 1, 1, 3, 3'b101), "rise_esc_dial");
        cyc(3'b101, 1, 1, 0, o(0, 1, 0, 3, 3'b101), "rise_esc_ack");
        cyc(3'b000, 1, 0, 0, o(0, 0, 0, 0, 3'b000), "rise_clear");

        // ACKED with burglar held, fire rises -> ALERT and escalation 7 edges later
        cyc(3'b010, 1, 0, 0, o(1, 1, 0, 2, 3'b010), "ackfire_burg");
        cyc(3'b010, 1, 1, 0, o(0, 1, 0, 2, 3'b010), "ackfire_acked");
        cyc(3'b110, 1, 0, 0, o(1, 1, 0, 3, 3'b110), "ackfire_realert");
        for (int k = 0; k < 6; k++) cyc(3'b110, 1, 0, 0, o(1, 1, 0, 3, 3'b110), "ackfire_wait");
        cyc(3'b110, 1, 0, 0, o(1, 1, 1, 3, 3'b110), "ackfire_dial");
        cyc(3'b110, 1, 0, 0, o(1, 1, 0, 3, 3'b110), "escalated_hold");
        cyc(3'b111, 1, 0, 0, o(1, 1, 0, 3, 3'b111), "escalated_rise_no_dial");
        cyc(3'b111, 1, 1, 0, o(0, 1, 0, 3, 3'b111), "escalated_ack");
        cyc(3'b000, 1, 0, 0, o(0, 0, 0, 0, 3'b000), "ackfire_clear");

        // Reset on the escalation edge suppresses dial_out and returns to IDLE
        for (int k = 0; k < 7; k++) cyc(3'b100, 1, 0, 0, o(1, 1, 0, 3, 3'b100), "rst_esc_alert");
        cyc(3'b100, 1, 0, 1, o(0, 0, 0, 0, 3'b000), "rst_on_esc_edge");
        cyc(3'b100, 1, 0, 0, o(1, 1, 0, 3, 3'b100), "rst_reentry");
        for (int k = 0; k < 6; k++) cyc(3'b100, 1, 0, 0, o(1, 1, 0, 3, 3'b100), "rst_fresh_timer");
        cyc(3'b100, 1, 0, 0, o(1, 1, 1, 3, 3'b100), "rst_fresh_dial");
        cyc(3'b000, 1, 0, 1, o(0, 0, 0, 0, 3'b000), "final_reset");

        for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge clk);
        @(posedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
